// File: rtl/image_pattern_generator.sv
// image_pattern_generator: streams one frame of pattern words into a screen RAM write port.
// Optional feature macro IMGGEN_AUTO_REPEAT_EN: frames repeat forever, odd frames inverted.
module image_pattern_generator #(
  parameter int DATA_W    = 16,
  parameter int ROW_WORDS = 32,
  parameter int ROWS      = 256,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              ready,
  output logic [ADDR_W-1:0] address,
  output logic              load,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              done
);

  localparam int CW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(ROW_WORDS - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

`ifdef IMGGEN_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              last_word;
  logic              invert;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic r0,
                                                input logic c0, input logic inv);
    logic lit;
    case (m)
      2'd0:    lit = 1'b0;
      2'd1:    lit = 1'b1;
      2'd2:    lit = r0 ^ c0;
      default: lit = r0;
    endcase
    return {DATA_W{lit ^ inv}};
  endfunction

  assign accept    = load_q && ready;
  assign last_word = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef IMGGEN_AUTO_REPEAT_EN
  // Frame parity flips as the last word of a frame is accepted, so the next frame is inverted.
  logic frame_q, frame_d;

  assign frame_d = frame_q ^ ((state_q == RUN) && accept && last_word);
  assign invert  = frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_q <= 1'b0;
    else       frame_q <= frame_d;
  end
`else
  assign invert = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      mode_q    <= '0;
      address_q <= '0;
      out_q     <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mode_q    <= mode_d;
      address_q <= address_d;
      out_q     <= out_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a register.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    mode_d    = mode_q;
    address_d = address_q;
    out_d     = out_q;
    load_d    = load_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = mode;
          row_d     = '0;
          col_d     = '0;
          address_d = BASE;
          out_d     = pattern(mode, 1'b0, 1'b0, invert);
          load_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_word) begin
            state_d = DONE;
            load_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = AUTO_REPEAT;
          end else begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            address_d = address_q + ADDR_W'(1);
            out_d     = pattern(mode_q, row_d[0], col_d[0], invert);
          end
        end
      end
      DONE: begin
        if (AUTO_REPEAT) begin
          state_d   = RUN;
          row_d     = '0;
          col_d     = '0;
          address_d = BASE;
          out_d     = pattern(mode_q, 1'b0, 1'b0, invert);
          load_d    = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        load_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign address = address_q;
  assign load    = load_q;
  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
